// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package inst_queue_pkg;

  typedef logic [31:0] inst_t;
  typedef logic [31:0] addr_t;

  localparam int    IQ_DEPTH = 8;
  localparam inst_t INST_NOP = 32'h0000_0013;  // addi x0,x0,0

  // One queue slot: fetched PC and its instruction word.
  typedef struct packed {
    addr_t pc;
    inst_t inst;
  } iq_entry_t;

  localparam int ENTRY_W = $bits(iq_entry_t);

endpackage

// File: rtl/inst_queue_ram.sv
// DEPTH x 64-bit storage: one synchronous write port, one asynchronous read
// port. Contents are deliberately not reset.
module inst_queue_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Write port: capture the incoming entry on the clock edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction fetch queue: circular FIFO of {pc, inst} between fetch and
// dispatch, valid/ready on both sides, single-cycle flush on redirect.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             push, pop;
  iq_entry_t        wr_entry, rd_entry;

  // Ready/valid depend only on registered occupancy, so a full queue refuses
  // a push even when dispatch pops in the same cycle.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wr_entry.pc   = in_pc;
  assign wr_entry.inst = in_inst;

  inst_queue_ram #(.DEPTH(DEPTH), .AW(PTR_W)) u_ram (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Pointers and occupancy; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head presentation: an empty queue shows PC 0 and a NOP to the decoders.
  always_comb begin
    out_pc   = '0;
    out_inst = INST_NOP;
    if (out_valid) begin
      out_pc   = rd_entry.pc;
      out_inst = rd_entry.inst;
    end
  end

endmodule
